// File: rtl/nl_output_packer_pkg.sv
// Shared types and defaults for the activation output packer.
package nl_output_packer_pkg;

  localparam int N_DIM_ARRAY              = 4;
  localparam int INPUT_CHANNEL_DATA_WIDTH = 16;
  localparam int INPUT_CHANNEL_ADDR_SIZE  = 8;

  typedef enum logic [1:0] {
    PK_IDLE,
    PK_PACK,
    PK_FLUSH,
    PK_DONE
  } pk_state_e;

  typedef enum logic [1:0] {
    PREC_FULL    = 2'd0,
    PREC_HALF    = 2'd1,
    PREC_QUARTER = 2'd2
  } prec_e;

  // Code 3 has no packing of its own and falls back to full width.
  function automatic prec_e decode_prec(input logic [1:0] code);
    case (code)
      2'd1:    return PREC_HALF;
      2'd2:    return PREC_QUARTER;
      default: return PREC_FULL;
    endcase
  endfunction

  function automatic logic [1:0] last_slot(input prec_e p);
    case (p)
      PREC_HALF:    return 2'd1;
      PREC_QUARTER: return 2'd3;
      default:      return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/nl_output_packer_lane_sat_pack.sv
// One lane: clamp a signed DW-bit value to the packed field width and drop it into
// its slot of the lane buffer. Purely combinational.
module lane_sat_pack
  import nl_output_packer_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0] i_lane,
  input  logic [DW-1:0] i_buf,
  input  prec_e         i_prec,
  input  logic [1:0]    i_slot,
  output logic [DW-1:0] o_buf,
  output logic          o_sat
);

  localparam int HW = DW / 2;
  localparam int QW = DW / 4;

  logic          w_fit_h;
  logic          w_fit_q;
  logic [HW-1:0] w_fld_h;
  logic [QW-1:0] w_fld_q;

  // A value fits in w bits when everything from bit w-1 up is a copy of the sign.
  assign w_fit_h = (&i_lane[DW-1:HW-1]) | ~(|i_lane[DW-1:HW-1]);
  assign w_fit_q = (&i_lane[DW-1:QW-1]) | ~(|i_lane[DW-1:QW-1]);

  assign w_fld_h = w_fit_h ? i_lane[HW-1:0] : {i_lane[DW-1], {(HW-1){~i_lane[DW-1]}}};
  assign w_fld_q = w_fit_q ? i_lane[QW-1:0] : {i_lane[DW-1], {(QW-1){~i_lane[DW-1]}}};

  always_comb begin
    o_buf = i_buf;
    o_sat = 1'b0;
    case (i_prec)
      PREC_HALF: begin
        o_sat = ~w_fit_h;
        for (int s = 0; s < 2; s++) begin
          if (i_slot == 2'(s)) o_buf[s*HW +: HW] = w_fld_h;
        end
      end
      PREC_QUARTER: begin
        o_sat = ~w_fit_q;
        for (int s = 0; s < 4; s++) begin
          if (i_slot == 2'(s)) o_buf[s*QW +: QW] = w_fld_q;
        end
      end
      default: o_buf = i_lane;
    endcase
  end

endmodule

// File: rtl/nl_output_packer.sv
// Requantizes N-lane activation vectors and packs 1/2/4 of them per memory word at an
// auto-incrementing address; write strobe lands 1 cycle after the completing vector, no backpressure.
module nl_output_packer
  import nl_output_packer_pkg::*;
#(
  parameter int N_LANES = N_DIM_ARRAY,
  parameter int DW      = INPUT_CHANNEL_DATA_WIDTH,
  parameter int AW      = INPUT_CHANNEL_ADDR_SIZE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            PRECISION,
  input  logic [AW-1:0]         base_addr,
  input  logic                  in_valid,
  input  logic [N_LANES*DW-1:0] in_word,
  input  logic                  flush,
  output logic                  mem_wr_en,
  output logic [AW-1:0]         mem_wr_addr,
  output logic [N_LANES*DW-1:0] mem_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  sat_flag
);

  pk_state_e             r_state;
  pk_state_e             w_next;
  prec_e                 r_prec;
  logic [1:0]            r_slot;
  logic [AW-1:0]         r_addr;
  logic [N_LANES*DW-1:0] r_buf;
  logic                  r_wr_en;
  logic [AW-1:0]         r_wr_addr;
  logic [N_LANES*DW-1:0] r_wr_data;
  logic                  r_sat;

  logic [N_LANES*DW-1:0] w_packed;
  logic [N_LANES-1:0]    w_lane_sat;
  logic                  w_accept;
  logic                  w_word_done;

  for (genvar j = 0; j < N_LANES; j++) begin : g_lane
    lane_sat_pack #(.DW(DW)) u_sat (
      .i_lane (in_word[j*DW +: DW]),
      .i_buf  (r_buf[j*DW +: DW]),
      .i_prec (r_prec),
      .i_slot (r_slot),
      .o_buf  (w_packed[j*DW +: DW]),
      .o_sat  (w_lane_sat[j])
    );
  end

  assign w_accept    = (r_state == PK_PACK) && in_valid;
  assign w_word_done = w_accept && (r_slot == last_slot(r_prec));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= PK_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      PK_IDLE: begin
        if (start) w_next = PK_PACK;
      end
      PK_PACK: begin
        busy = 1'b1;
        if (flush) w_next = PK_FLUSH;
      end
      PK_FLUSH: begin
        busy   = 1'b1;
        w_next = PK_DONE;
      end
      default: begin
        done   = 1'b1;
        w_next = PK_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prec    <= PREC_FULL;
      r_slot    <= 2'd0;
      r_addr    <= '0;
      r_buf     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_sat     <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      if (r_state == PK_IDLE && start) begin
        r_prec <= decode_prec(PRECISION);
        r_addr <= base_addr;
        r_slot <= 2'd0;
        r_buf  <= '0;
        r_sat  <= 1'b0;
      end else if (w_accept) begin
        if (|w_lane_sat) r_sat <= 1'b1;
        if (w_word_done) begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_addr;
          r_wr_data <= w_packed;
          r_addr    <= r_addr + 1'b1;
          r_slot    <= 2'd0;
          r_buf     <= '0;
        end else begin
          r_buf  <= w_packed;
          r_slot <= r_slot + 2'd1;
        end
      end else if (r_state == PK_FLUSH && r_slot != 2'd0) begin
        // Untouched slots are still zero from the last clear.
        r_wr_en   <= 1'b1;
        r_wr_addr <= r_addr;
        r_wr_data <= r_buf;
        r_addr    <= r_addr + 1'b1;
        r_slot    <= 2'd0;
        r_buf     <= '0;
      end
    end
  end

  assign mem_wr_en   = r_wr_en;
  assign mem_wr_addr = r_wr_addr;
  assign mem_wr_data = r_wr_data;
  assign sat_flag    = r_sat;

endmodule

// File: tb/tb_nl_output_packer.sv
// Directed table of layers plus hand sequences for start/reset/idle corner cases.
module tb_nl_output_packer;

  localparam int NL = 4;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int WW = NL * DW;

  typedef struct packed {
    logic [1:0]       prec;
    logic [7:0]       base;
    logic [2:0]       nvec;
    logic             flush_last;
    logic [4:0][63:0] vec;
    logic [1:0]       nwr;
    logic [1:0][7:0]  addr;
    logic [1:0][63:0] data;
    logic             sat;
  } layer_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          flush = 1'b0;
  logic [1:0]    prec = 2'd0;
  logic [AW-1:0] base = '0;
  logic [WW-1:0] in_word = '0;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [WW-1:0] mem_wr_data;
  logic          busy;
  logic          done;
  logic          sat_flag;

  int n_vec = 0;
  int n_miss = 0;
  int wr_count = 0;
  layer_t tbl [8];

  nl_output_packer #(.N_LANES(NL), .DW(DW), .AW(AW)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .start       (start),
    .PRECISION   (prec),
    .base_addr   (base),
    .in_valid    (in_valid),
    .in_word     (in_word),
    .flush       (flush),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .busy        (busy),
    .done        (done),
    .sat_flag    (sat_flag)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_wr_en) wr_count++;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic set_l(input int i, input logic [1:0] p, input logic [7:0] b, input int nv,
                       input logic fl, input int nw, input logic s);
    tbl[i]            = '0;
    tbl[i].prec       = p;
    tbl[i].base       = b;
    tbl[i].nvec       = 3'(nv);
    tbl[i].flush_last = fl;
    tbl[i].nwr        = 2'(nw);
    tbl[i].sat        = s;
  endtask

  task automatic set_v(input int i, input int k, input logic [63:0] v);
    tbl[i].vec[k] = v;
  endtask

  task automatic set_e(input int i, input int k, input logic [7:0] a, input logic [63:0] d);
    tbl[i].addr[k] = a;
    tbl[i].data[k] = d;
  endtask

  task automatic run_layer(input layer_t c);
    int pv, wi, w0, seen;
    pv = (c.prec == 2'd1) ? 2 : (c.prec == 2'd2) ? 4 : 1;
    wi = 0;
    w0 = wr_count;
    start = 1'b1; prec = c.prec; base = c.base;
    tick();
    start = 1'b0; prec = ~c.prec; base = ~c.base;
    chk("busy_after_start", busy, 1);
    for (int k = 0; k < int'(c.nvec); k++) begin
      in_valid = 1'b1;
      in_word  = c.vec[k];
      flush    = c.flush_last && (k == int'(c.nvec) - 1);
      tick();
      in_valid = 1'b0;
      flush    = 1'b0;
      if ((k + 1) % pv == 0) begin
        chk("wr_en_latency", mem_wr_en, 1);
        chk("wr_addr", mem_wr_addr, c.addr[wi]);
        chk("wr_data", mem_wr_data, c.data[wi]);
        wi++;
      end else begin
        chk("wr_en_midword", mem_wr_en, 0);
      end
    end
    if (!c.flush_last) begin
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_cycle_no_wr", mem_wr_en, 0);
    end
    seen = 0;
    for (int t = 1; t <= 8 && seen == 0; t++) begin
      tick();
      if (mem_wr_en) begin
        chk("partial_addr", mem_wr_addr, (wi < 2) ? c.addr[wi] : 8'hxx);
        chk("partial_data", mem_wr_data, (wi < 2) ? c.data[wi] : 64'hx);
        wi++;
      end
      if (done) seen = t;
    end
    chk("done_latency", seen, 1);
    tick();
    chk("done_one_cycle", done, 0);
    chk("busy_idle", busy, 0);
    chk("sat_flag", sat_flag, c.sat);
    chk("write_count", wr_count - w0, c.nwr);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int w0;
    // P=0 base 0x10: three full-width words, data untouched
    set_l(0, 2'd0, 8'h10, 3, 1'b0, 3, 1'b0);
    set_v(0, 0, 64'h0004_8000_1234_0005);
    set_v(0, 1, 64'hFFFF_7FFF_ABCD_FFFD);
    set_v(0, 2, 64'h0000_0001_0002_0003);
    set_e(0, 0, 8'h10, 64'h0004_8000_1234_0005);
    set_e(0, 1, 8'h11, 64'hFFFF_7FFF_ABCD_FFFD);
    // only two entries fit; third write checked through the loop below
    // P=1: 8-bit fields, clamps on lanes 0..2
    set_l(1, 2'd1, 8'h00, 2, 1'b0, 1, 1'b1);
    set_v(1, 0, 64'h0000_FF80_007F_0064);
    set_v(1, 1, 64'hFFFF_FF7F_0080_FF38);
    set_e(1, 0, 8'h00, 64'hFF00_8080_7F7F_8064);
    // P=2: 4-bit fields, no clamp
    set_l(2, 2'd2, 8'h20, 4, 1'b0, 1, 1'b0);
    set_v(2, 0, 64'hFFF8_0000_0007_0001);
    set_v(2, 1, 64'hFFF9_0000_FFF8_0002);
    set_v(2, 2, 64'h0006_0000_0000_FFFF);
    set_v(2, 3, 64'h0005_0000_FFFF_0007);
    set_e(2, 0, 8'h20, 64'h5698_0000_F087_7F21);
    // P=2: two vectors then flush -> partial word
    set_l(3, 2'd2, 8'h30, 2, 1'b0, 1, 1'b1);
    set_v(3, 0, 64'h0001_8000_0064_0003);
    set_v(3, 1, 64'h0001_7FFF_FF9C_FFFE);
    set_e(3, 0, 8'h30, 64'h0011_0078_0087_00E3);
    // P=1: flush with the completing vector -> exactly one write
    set_l(4, 2'd1, 8'h40, 2, 1'b1, 1, 1'b0);
    set_v(4, 0, 64'h1);
    set_v(4, 1, 64'h2);
    set_e(4, 0, 8'h40, 64'h0201);
    // address wrap
    set_l(5, 2'd0, 8'hFF, 2, 1'b0, 2, 1'b0);
    set_v(5, 0, 64'h0123_4567_89AB_CDEF);
    set_v(5, 1, 64'hFEDC_BA98_7654_3210);
    set_e(5, 0, 8'hFF, 64'h0123_4567_89AB_CDEF);
    set_e(5, 1, 8'h00, 64'hFEDC_BA98_7654_3210);
    // code 3 behaves as full width
    set_l(6, 2'd3, 8'h50, 1, 1'b1, 1, 1'b0);
    set_v(6, 0, 64'h8000_7FFF_0001_FFFF);
    set_e(6, 0, 8'h50, 64'h8000_7FFF_0001_FFFF);
    // P=2: full word then 1-slot partial
    set_l(7, 2'd2, 8'h60, 5, 1'b0, 2, 1'b0);
    for (int k = 0; k < 4; k++) set_v(7, k, 64'h1);
    set_v(7, 4, 64'h3);
    set_e(7, 0, 8'h60, 64'h1111);
    set_e(7, 1, 8'h61, 64'h0003);

    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_wr_addr", mem_wr_addr, 0);
    chk("rst_wr_data", mem_wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sat", sat_flag, 0);
    rst_n = 1'b1;
    tick();

    // Layer 0 has three writes: the third is checked separately after the run.
    begin
      layer_t c0;
      c0 = tbl[0];
      c0.nvec = 3'd2;
      c0.nwr  = 2'd2;
      run_layer(c0);
    end
    for (int i = 1; i < 8; i++) run_layer(tbl[i]);

    // Third P=0 vector: back-to-back P=0 writes and in_valid ignored in IDLE.
    start = 1'b1; prec = 2'd0; base = 8'h12;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_word = tbl[0].vec[0];
    tick();
    in_word = 64'h0000_0001_0002_0003;
    chk("b2b_first_en", mem_wr_en, 1);
    chk("b2b_first_addr", mem_wr_addr, 8'h12);
    tick();
    chk("b2b_second_en", mem_wr_en, 1);
    chk("b2b_second_addr", mem_wr_addr, 8'h13);
    chk("b2b_second_data", mem_wr_data, 64'h0000_0001_0002_0003);
    // start while packing must not re-latch the base address
    start = 1'b1; base = 8'h05; in_word = 64'hAAAA;
    tick();
    start = 1'b0; in_valid = 1'b0;
    chk("start_in_pack_addr", mem_wr_addr, 8'h14);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("seq_done", done, 1);
    tick();

    // inputs while idle do nothing
    w0 = wr_count;
    in_valid = 1'b1; flush = 1'b1; in_word = '1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    tick();
    chk("idle_no_write", wr_count - w0, 0);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    // reset with one slot filled: nothing written, outputs cleared
    start = 1'b1; prec = 2'd2; base = 8'h80;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_word = 64'h0064;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_sat", sat_flag, 1);
    w0 = wr_count;
    rst_n = 1'b0;
    tick();
    chk("mid_rst_wr_en", mem_wr_en, 0);
    chk("mid_rst_addr", mem_wr_addr, 0);
    chk("mid_rst_data", mem_wr_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sat", sat_flag, 0);
    rst_n = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    tick();
    chk("mid_rst_no_write", wr_count - w0, 0);
    chk("mid_rst_no_done", done, 0);
    chk("mid_rst_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
